// File: rtl/fetch_buffer_if.sv
// Fetch-buffer bus bundle: instruction memory port plus decode-side handshake.
// Latency: n/a (signal bundle only).
// Backpressure: dec_valid/dec_ready handshake; redirect overrides both directions.
interface fetch_buffer_if #(
    parameter int DEPTH = 4
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic [31:0]   imem_adr;
    logic [31:0]   imem_instr;
    logic          redirect;
    logic [31:0]   redirect_pc;
    logic          dec_valid;
    logic          dec_ready;
    logic [31:0]   dec_instr;
    logic [31:0]   dec_pc_plus4;
    logic [LW-1:0] level;

    // Fetch-buffer side
    modport master (
        output imem_adr,
        input  imem_instr,
        input  redirect,
        input  redirect_pc,
        output dec_valid,
        input  dec_ready,
        output dec_instr,
        output dec_pc_plus4,
        output level
    );

    // Environment side: instruction memory, decode stage, branch resolution
    modport slave (
        input  imem_adr,
        output imem_instr,
        output redirect,
        output redirect_pc,
        input  dec_valid,
        output dec_ready,
        input  dec_instr,
        input  dec_pc_plus4,
        input  level
    );
endinterface

// File: rtl/fetch_buffer.sv
// Instruction fetch front-end: owns the PC, queues {pc+4, instr} into a DEPTH-entry FIFO for decode.
// Latency: a word fetched in cycle N is visible to decode in N+1; redirect target appears two edges later.
// Backpressure: fetch stalls (PC holds) while full; redirect flushes the FIFO. Optional macro FETCH_BUFFER_STATS_EN adds stall/flush counters.
module fetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef FETCH_BUFFER_STATS_EN
    output logic [31:0]           stall_cycles,
    output logic [31:0]           flush_count,
`endif
    fetch_buffer_if.master        bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [31:0]   pc_q;
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [LW-1:0] level_q;
    logic [LW-1:0] level_d;

    logic [31:0]   instr_mem [DEPTH];
    logic [31:0]   pc4_mem   [DEPTH];

    logic          full;
    logic          empty;
    logic          push;
    logic          pop;
    logic [31:0]   pc_plus4;

    assign full     = (level_q == LW'(DEPTH));
    assign empty    = (level_q == '0);
    assign pc_plus4 = pc_q + 32'd4;

    // A full buffer never pushes, even if decode frees a slot this cycle; redirect blocks both sides.
    assign push = !full && !bus.redirect;
    assign pop  = bus.dec_valid && bus.dec_ready;

    assign bus.imem_adr     = pc_q;
    assign bus.dec_valid    = !empty && !bus.redirect;
    assign bus.dec_instr    = empty ? 32'd0 : instr_mem[rd_ptr_q];
    assign bus.dec_pc_plus4 = empty ? 32'd0 : pc4_mem[rd_ptr_q];
    assign bus.level        = level_q;

    // Next occupancy from the push/pop pair; redirect override is applied in the register.
    always_comb begin
        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push) begin
            level_d = level_q - LW'(1);
        end
    end

    // PC, pointers and occupancy; redirect has priority and restarts the queue from its target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q     <= RESET_PC;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (bus.redirect) begin
            pc_q     <= {bus.redirect_pc[31:2], 2'b00};
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                pc_q     <= pc_plus4;
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            level_q <= level_d;
        end
    end

    // Entry storage; contents are masked by level, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr_q] <= bus.imem_instr;
            pc4_mem[wr_ptr_q]   <= pc_plus4;
        end
    end

`ifdef FETCH_BUFFER_STATS_EN
    // Saturating counters of full cycles and redirect cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (full && (stall_cycles != 32'hFFFF_FFFF)) begin
                stall_cycles <= stall_cycles + 32'd1;
            end
            if (bus.redirect && (flush_count != 32'hFFFF_FFFF)) begin
                flush_count <= flush_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer: fill/drain, redirect, PC wrap, async reset, optional stats.
// Latency: n/a.
// Backpressure: exercised via dec_ready and redirect.
module tb_fetch_buffer;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    fetch_buffer_if #(.DEPTH(4)) bus ();

    // Combinational instruction memory: word content derived from its address.
    assign bus.imem_instr = bus.imem_adr ^ 32'hA5A5_0000;

`ifdef FETCH_BUFFER_STATS_EN
    logic [31:0] stall_cycles;
    logic [31:0] flush_count;
`endif

    fetch_buffer #(
        .DEPTH    (4),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst          (rst),
`ifdef FETCH_BUFFER_STATS_EN
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count),
`endif
        .bus          (bus.master)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst             = 1'b1;
        bus.dec_ready   = 1'b1;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'd0;

        // Reset state, before any clock edge
        #3;
        chk("rst_level", 32'(bus.level), 32'd0);
        chk("rst_valid", 32'(bus.dec_valid), 32'd0);
        chk("rst_adr", bus.imem_adr, 32'd0);
        chk("rst_instr", bus.dec_instr, 32'd0);
        chk("rst_pc4", bus.dec_pc_plus4, 32'd0);

        // Streaming with dec_ready = 1
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("s1_valid", 32'(bus.dec_valid), 32'd1);
        chk("s1_level", 32'(bus.level), 32'd1);
        chk("s1_pc4", bus.dec_pc_plus4, 32'd4);
        chk("s1_instr", bus.dec_instr, 32'hA5A5_0000);
        step();
        chk("s2_level", 32'(bus.level), 32'd1);
        chk("s2_pc4", bus.dec_pc_plus4, 32'd8);
        chk("s2_instr", bus.dec_instr, 32'hA5A5_0004);
        step();
        chk("s3_level", 32'(bus.level), 32'd1);
        chk("s3_pc4", bus.dec_pc_plus4, 32'd12);
        chk("s3_instr", bus.dec_instr, 32'hA5A5_0008);
        chk("s3_adr", bus.imem_adr, 32'd12);

        // Fill to full with decode stalled
        rst = 1'b1;
        #1;
        rst = 1'b0;
        bus.dec_ready = 1'b0;
        repeat (4) step();
        chk("f_level", 32'(bus.level), 32'd4);
        chk("f_adr", bus.imem_adr, 32'h10);
        chk("f_valid", 32'(bus.dec_valid), 32'd1);
        chk("f_pc4", bus.dec_pc_plus4, 32'd4);
        step();
        chk("f_hold_level", 32'(bus.level), 32'd4);
        chk("f_hold_adr", bus.imem_adr, 32'h10);

        // Drain: first pop frees a slot but no push that cycle
        bus.dec_ready = 1'b1;
        step();
        chk("d1_level", 32'(bus.level), 32'd3);
        chk("d1_pc4", bus.dec_pc_plus4, 32'd8);
        chk("d1_adr", bus.imem_adr, 32'h10);
        step();
        chk("d2_level", 32'(bus.level), 32'd3);
        chk("d2_pc4", bus.dec_pc_plus4, 32'd12);
        chk("d2_adr", bus.imem_adr, 32'h14);
        step();
        chk("d3_level", 32'(bus.level), 32'd3);
        chk("d3_pc4", bus.dec_pc_plus4, 32'd16);
        chk("d3_adr", bus.imem_adr, 32'h18);

        // Redirect at level 3
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h100;
        #1;
        chk("r_valid_now", 32'(bus.dec_valid), 32'd0);
        step();
        bus.redirect = 1'b0;
        #1;
        chk("r_level", 32'(bus.level), 32'd0);
        chk("r_adr", bus.imem_adr, 32'h100);
        chk("r_valid", 32'(bus.dec_valid), 32'd0);
        step();
        chk("r_pc4", bus.dec_pc_plus4, 32'h104);
        chk("r_instr", bus.dec_instr, 32'hA5A5_0100);
        chk("r_level1", 32'(bus.level), 32'd1);

        // Misaligned target, then back-to-back redirect to the top word
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0000_0103;
        step();
        chk("ma_adr", bus.imem_adr, 32'h100);
        bus.redirect_pc = 32'hFFFF_FFFC;
        step();
        chk("w_adr", bus.imem_adr, 32'hFFFF_FFFC);
        chk("w_level", 32'(bus.level), 32'd0);
        bus.redirect = 1'b0;
        step();
        chk("w_pc4", bus.dec_pc_plus4, 32'd0);
        chk("w_instr", bus.dec_instr, 32'h5A5A_FFFC);
        chk("w_adr0", bus.imem_adr, 32'd0);
        chk("w_valid", 32'(bus.dec_valid), 32'd1);

        // Async reset mid-cycle with two entries held
        bus.dec_ready   = 1'b0;
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h40;
        step();
        bus.redirect = 1'b0;
        step();
        step();
        chk("ar_pre_level", 32'(bus.level), 32'd2);
        chk("ar_pre_adr", bus.imem_adr, 32'h48);
        #2;
        rst = 1'b1;
        #1;
        chk("ar_level", 32'(bus.level), 32'd0);
        chk("ar_valid", 32'(bus.dec_valid), 32'd0);
        chk("ar_adr", bus.imem_adr, 32'd0);
        chk("ar_pc4", bus.dec_pc_plus4, 32'd0);
        @(negedge clk);
        rst = 1'b0;

`ifdef FETCH_BUFFER_STATS_EN
        // Ten stalled cycles: four fill, six full; then two redirects
        repeat (10) step();
        chk("st_stall", stall_cycles, 32'd6);
        chk("st_flush0", flush_count, 32'd0);
        bus.redirect    = 1'b1;
        bus.redirect_pc = 32'h0;
        repeat (2) step();
        bus.redirect = 1'b0;
        #1;
        chk("st_flush", flush_count, 32'd2);
        chk("st_stall2", stall_cycles, 32'd7);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
